// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: line-sized pmem handshake shared by the I-cache, D-cache and memory sides
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic              resp;
    logic [LINE_W-1:0] rdata;

    modport master (output read, write, address, wdata, input resp, rdata);
    modport slave  (input read, write, address, wdata, output resp, rdata);
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter of I-cache and D-cache line transactions onto one pmem port
module pmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    pmem_arbiter_if.slave  icache,
    pmem_arbiter_if.slave  dcache,
    pmem_arbiter_if.master pmem,
    output logic          pmem_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT_I, S_GRANT_D, S_RELEASE} state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_WAIT);

    state_t        r_state;
    logic          r_last_d;
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;

    logic w_i_req, w_d_req, w_gi, w_gd, w_own_req, w_d_rd, w_unused_i;

    assign w_i_req    = icache.read;
    assign w_d_req    = dcache.read | dcache.write;
    assign w_gi       = (r_state == S_GRANT_I);
    assign w_gd       = (r_state == S_GRANT_D);
    assign w_own_req  = w_gi ? w_i_req : w_d_req;
    // an illegal read+write from the D-cache is treated as a writeback
    assign w_d_rd     = dcache.read & ~dcache.write;
    assign w_unused_i = icache.write | (|icache.wdata);

    // arbitration, completion/abort tracking and the sticky watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_i_req && (!w_d_req || r_last_d))
                        r_state <= S_GRANT_I;
                    else if (w_d_req)
                        r_state <= S_GRANT_D;
                end
                S_GRANT_I, S_GRANT_D: begin
                    if (pmem.resp) begin
                        r_state  <= S_RELEASE;
                        r_last_d <= w_gd;
                    end else begin
                        if (!w_own_req)
                            r_state <= S_IDLE;
                        if (r_wait_cnt != W_MAX)
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == W_MAX - 1'b1)
                            r_timeout <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pmem.read    = w_gi ? icache.read : (w_gd & w_d_rd);
    assign pmem.write   = w_gd & dcache.write;
    assign pmem.address = w_gi ? icache.address : w_gd ? dcache.address : {ADDR_W{1'b0}};
    assign pmem.wdata   = w_gd ? dcache.wdata : {LINE_W{1'b0}};
    assign icache.resp  = w_gi & pmem.resp;
    assign icache.rdata = w_gi ? pmem.rdata : {LINE_W{1'b0}};
    assign dcache.resp  = w_gd & pmem.resp;
    assign dcache.rdata = w_gd ? pmem.rdata : {LINE_W{1'b0}};
    assign pmem_timeout = r_timeout;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed and randomized checks of pmem_arbiter against a behavioural model
module tb_pmem_arbiter;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic timeout;

    pmem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) ic_if ();
    pmem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) dc_if ();
    pmem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) pm_if ();

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset_n(reset_n), .icache(ic_if), .dcache(dc_if), .pmem(pm_if), .pmem_timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: owner of the port (-1 none, 0 I, 1 D), turnaround flag, round-robin memory, watchdog
    int m_own = -1;
    int m_last = 0;
    int m_wait = 0;
    bit m_cool = 0;
    bit m_to = 0;
    wire [1:0] req = {dc_if.read | dc_if.write, ic_if.read};

    // model advances on every clock edge and resets asynchronously
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own <= -1; m_last <= 0; m_wait <= 0; m_cool <= 0; m_to <= 0;
        end else if (m_cool) begin
            m_cool <= 0;
        end else if (m_own < 0) begin
            if (req == 2'b11) m_own <= 1 - m_last;
            else if (req[0]) m_own <= 0;
            else if (req[1]) m_own <= 1;
            m_wait <= 0;
        end else if (pm_if.resp) begin
            m_last <= m_own; m_own <= -1; m_cool <= 1;
        end else begin
            if (!req[m_own]) m_own <= -1;
            m_wait <= (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
            if (m_wait + 1 >= MAXW) m_to <= 1;
        end
    end

    bit e_gi, e_gd;
    // compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        e_gi = (m_own == 0);
        e_gd = (m_own == 1);
        chk("pmem_read", pm_if.read, e_gi ? ic_if.read : e_gd ? (dc_if.read & ~dc_if.write) : 1'b0);
        chk("pmem_write", pm_if.write, e_gd & dc_if.write);
        chk("pmem_address", pm_if.address, e_gi ? ic_if.address : e_gd ? dc_if.address : 16'h0);
        chk("pmem_wdata", pm_if.wdata, e_gd ? dc_if.wdata : 128'h0);
        chk("i_resp", ic_if.resp, e_gi & pm_if.resp);
        chk("i_rdata", ic_if.rdata, e_gi ? pm_if.rdata : 128'h0);
        chk("d_resp", dc_if.resp, e_gd & pm_if.resp);
        chk("d_rdata", dc_if.rdata, e_gd ? pm_if.rdata : 128'h0);
        chk("timeout", timeout, m_to);
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        cyc; cyc;
        reset_n = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] w_d2 = 128'hDDDD_0000_1111_2222_3333_4444_5555_6666;
    bit i_got, d_got;
    int r;

    initial begin
        ic_if.read = 0; ic_if.write = 0; ic_if.address = 0; ic_if.wdata = 0;
        dc_if.read = 0; dc_if.write = 0; dc_if.address = 0; dc_if.wdata = 0;
        pm_if.resp = 0; pm_if.rdata = 0;
        cyc; neg;
        chk("rst_read", pm_if.read, 0);
        chk("rst_addr", pm_if.address, 0);
        chk("rst_timeout", timeout, 0);
        cyc;
        reset_n = 1'b1;
        // I-only read with a three-cycle memory latency
        cyc;
        ic_if.read = 1; ic_if.address = 16'h1230;
        neg; chk("t1_idle_read", pm_if.read, 0);
        cyc; neg;
        chk("t1_c1_read", pm_if.read, 1);
        chk("t1_c1_addr", pm_if.address, 16'h1230);
        cyc; neg; chk("t1_c2_read", pm_if.read, 1);
        cyc;
        pm_if.resp = 1; pm_if.rdata = {16{8'hA5}};
        neg;
        chk("t1_c3_iresp", ic_if.resp, 1);
        chk("t1_c3_irdata", ic_if.rdata, {16{8'hA5}});
        cyc;
        pm_if.resp = 0; ic_if.read = 0;
        neg;
        chk("t1_rel_read", pm_if.read, 0);
        chk("t1_rel_iresp", ic_if.resp, 0);
        // four back-to-back ties after reset alternate D, I, D, I
        do_reset;
        ic_if.read = 1; ic_if.address = 16'h0100;
        dc_if.write = 1; dc_if.address = 16'h0200; dc_if.wdata = w_d2;
        for (int k = 0; k < 4; k++) begin
            cyc;
            pm_if.resp = 1; pm_if.rdata = 128'(k + 7);
            neg;
            chk("t2_write", pm_if.write, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("t2_read", pm_if.read, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk("t2_addr", pm_if.address, (k % 2 == 0) ? 16'h0200 : 16'h0100);
            if (k == 0) chk("t2_wdata", pm_if.wdata, w_d2);
            chk("t2_dresp", dc_if.resp, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("t2_iresp", ic_if.resp, (k % 2 == 0) ? 1'b0 : 1'b1);
            cyc;
            pm_if.resp = 0;
            if (k % 2 == 0) dc_if.write = 0; else ic_if.read = 0;
            neg; chk("t2_rel_strobe", pm_if.read | pm_if.write, 0);
            cyc;
            if (k % 2 == 0) dc_if.write = 1; else ic_if.read = 1;
        end
        ic_if.read = 0; dc_if.write = 0;
        cyc; cyc;
        // D read while an I request stalls
        dc_if.read = 1; dc_if.address = 16'h0300;
        cyc;
        ic_if.read = 1; ic_if.address = 16'h0333;
        neg; chk("t3_addr", pm_if.address, 16'h0300);
        cyc; neg; chk("t3_iresp_stall", ic_if.resp, 0);
        cyc;
        pm_if.resp = 1; pm_if.rdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        neg;
        chk("t3_drdata", dc_if.rdata, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
        chk("t3_iresp", ic_if.resp, 0);
        chk("t3_irdata", ic_if.rdata, 0);
        cyc;
        pm_if.resp = 0; dc_if.read = 0;
        cyc; cyc;
        neg; chk("t3_i_served", pm_if.address, 16'h0333);
        pm_if.resp = 1;
        cyc;
        pm_if.resp = 0; ic_if.read = 0;
        cyc; cyc;
        // D aborts mid-grant; then reset mid I-grant
        dc_if.read = 1; dc_if.address = 16'h0400;
        cyc; neg; chk("t5_dread", pm_if.read, 1);
        cyc;
        dc_if.read = 0;
        neg; chk("t5_abort_dresp", dc_if.resp, 0);
        cyc;
        pm_if.resp = 1; ic_if.read = 1; ic_if.address = 16'h0500;
        neg; chk("t5_stray_dresp", dc_if.resp, 0);
        cyc;
        pm_if.resp = 0;
        neg;
        chk("t5_grant_i", pm_if.read, 1);
        chk("t5_grant_i_addr", pm_if.address, 16'h0500);
        cyc;
        #2 reset_n = 0;
        #1 chk("t5_rst_read", pm_if.read, 0);
        cyc;
        reset_n = 1; ic_if.read = 0;
        cyc; cyc;
        // illegal D read+write, then stray resp in IDLE
        dc_if.read = 1; dc_if.write = 1; dc_if.address = 16'h0600; dc_if.wdata = 128'h66;
        cyc;
        pm_if.resp = 1;
        neg;
        chk("t6_write", pm_if.write, 1);
        chk("t6_read", pm_if.read, 0);
        chk("t6_dresp", dc_if.resp, 1);
        cyc;
        pm_if.resp = 0; dc_if.read = 0; dc_if.write = 0;
        cyc; cyc;
        pm_if.resp = 1;
        neg;
        chk("t6_stray_i", ic_if.resp, 0);
        chk("t6_stray_d", dc_if.resp, 0);
        cyc;
        pm_if.resp = 0; ic_if.read = 1; ic_if.address = 16'h0700;
        cyc; neg; chk("t6_grant_after", pm_if.read, 1);
        pm_if.resp = 1;
        cyc;
        pm_if.resp = 0; ic_if.read = 0;
        // watchdog
        do_reset;
        ic_if.read = 1; ic_if.address = 16'h0800;
        for (int k = 1; k <= 4; k++) begin
            cyc; neg; chk("t4_before", timeout, 0);
        end
        cyc; neg; chk("t4_set", timeout, 1);
        pm_if.resp = 1;
        cyc;
        pm_if.resp = 0; ic_if.read = 0;
        cyc; cyc; neg; chk("t4_sticky", timeout, 1);
        do_reset;
        neg; chk("t4_cleared", timeout, 0);
        // randomized traffic with asynchronous reset pulses between rounds
        for (int round = 0; round < 4; round++) begin
            for (int n = 0; n < 500; n++) begin
                neg;
                i_got = ic_if.resp; d_got = dc_if.resp;
                cyc;
                if (ic_if.read) begin
                    if (i_got || $urandom_range(0, 19) == 0) ic_if.read = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    ic_if.read = 1; ic_if.address = 16'($urandom);
                end
                if (dc_if.read | dc_if.write) begin
                    if (d_got || $urandom_range(0, 19) == 0) begin
                        dc_if.read = 0; dc_if.write = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 9);
                    dc_if.read = (r < 5) || (r == 9);
                    dc_if.write = (r >= 5);
                    dc_if.address = 16'($urandom);
                    dc_if.wdata = rnd128();
                end
                pm_if.resp = ($urandom_range(0, 2) == 0);
                pm_if.rdata = rnd128();
            end
            @(posedge clk);
            #($urandom_range(2, 7)) reset_n = 0;
            cyc;
            reset_n = 1;
        end
        cyc;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the CPU's split L1 instruction and data caches, between their physical-memory-side ports and the single physical memory port.
- Arbitrates line-sized (128-bit) read/write transactions from the I-cache and D-cache onto one shared pmem handshake.
- Grants round-robin on contention.
- Provides a sticky watchdog flag for hung transactions.

Parameters:
- ADDR_W, 16, byte address width (lc3b_word).
- LINE_W, 128, cache line width (lc3b_mem_data).
- MAX_WAIT, 255, max cycles a grant may stay open without pmem_resp before the timeout flag sets; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  I-cache line address.
- i_pmem_resp  out  1  I-cache transaction complete.
- i_pmem_rdata  out  LINE_W  I-cache read line.
- d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp.
- d_pmem_write  in  1  D-cache line writeback request, held until d_pmem_resp.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache writeback line.
- d_pmem_resp  out  1  D-cache transaction complete.
- d_pmem_rdata  out  LINE_W  D-cache read line.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_W  physical memory address.
- pmem_wdata  out  LINE_W  physical memory write line.
- pmem_resp  in  1  physical memory done.
- pmem_rdata  in  LINE_W  physical memory read line.
- pmem_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, last_grant=I, wait_cnt=0, pmem_timeout=0.
  - All strobes and resp outputs are 0; pmem_address, pmem_wdata, i_pmem_rdata and d_pmem_rdata are 0.
  - Reset asserted mid-transaction aborts it: strobes drop asynchronously and no resp is issued.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - No pmem strobes.
  - Sampled at the clock edge: only I pending -> GRANT_I; only D pending (read or write) -> GRANT_D.
  - Both pending -> grant the requester opposite last_grant. After reset the first tie therefore goes to D.
  - Neither pending -> stay in IDLE.
- GRANT_I:
  - Combinational forwarding: pmem_read=i_pmem_read, pmem_write=0, pmem_address=i_pmem_address.
  - i_pmem_resp=pmem_resp and i_pmem_rdata=pmem_rdata in the same cycle (zero added latency on the return path).
- GRANT_D:
  - Combinational forwarding: pmem_read=d_pmem_read, pmem_write=d_pmem_write, pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
  - d_pmem_resp=pmem_resp and d_pmem_rdata=pmem_rdata in the same cycle.
  - d_pmem_read and d_pmem_write both high is illegal. The arbiter forwards the write only (pmem_read=0) and completes it normally.
- Exit from a GRANT state:
  - pmem_resp=1 -> RELEASE; last_grant <= granted side.
  - Granted requester deasserts its request(s) before resp -> abort to IDLE; last_grant unchanged.
- RELEASE:
  - Exactly one cycle with all strobes and resps at 0 (bus turnaround, and lets the cache drop its request), then IDLE.
  - Minimum request-to-request spacing through the arbiter is therefore 2 cycles after a resp.
- Non-granted side:
  - resp held 0; rdata output 0.
  - Its request remains pending and is served after RELEASE/IDLE.
- Latency: a request first seen high in IDLE is driven onto pmem on the next cycle (one cycle of arbitration).
- Watchdog:
  - wait_cnt clears on entering a GRANT state and increments each GRANT cycle without pmem_resp.
  - When wait_cnt reaches MAX_WAIT, pmem_timeout <= 1 and stays 1 until reset.
  - The transaction is not aborted by the watchdog; wait_cnt saturates.
- pmem_resp while in IDLE or RELEASE is ignored: no resp is forwarded and no state change occurs.

Test Plan:
1. I-only read: i_pmem_read=1, addr=0x1230 at cycle 0; pmem_resp=1 at cycle 3 with rdata=0xA5...A5 -> pmem_read=1, pmem_address=0x1230 in cycles 1-3; i_pmem_resp=1 and i_pmem_rdata=0xA5...A5 in cycle 3; all strobes 0 in cycle 4 (RELEASE).
2. Simultaneous I read and D write immediately after reset -> D granted first (pmem_write=1, addr/wdata from D); after D's resp and RELEASE, I is granted; next tie goes to D again (alternation verified over 4 back-to-back ties).
3. D read with a stalled I request: I is never granted and i_pmem_resp stays 0 while GRANT_D is active; d_pmem_rdata matches pmem_rdata in the resp cycle.
4. Watchdog: MAX_WAIT=4, grant open with no pmem_resp -> pmem_timeout rises after the 4th GRANT cycle and stays 1 after a later resp, until reset_n=0.
5. Abort and reset: D deasserts d_pmem_read mid-grant -> IDLE next cycle with no resp. Separately, reset_n pulsed low mid-GRANT_I -> pmem_read drops immediately and state=IDLE.
6. Illegal D read+write together -> only pmem_write=1 is forwarded; pmem_resp is stray-pulsed in IDLE -> no resp output, state unchanged.
